// File: rtl/vga_sync_gen.sv
// vga_sync_gen
// -----------------------------------------------------------------------------
// VGA raster timing generator (640x480@60 by default). A small divider turns
// the system clock into a one-clock pixel tick; a horizontal and a vertical
// position counter advance on that tick. hsync, vsync and video_on are
// registered from decodes of the next counter values, so they change on the
// same edge as pixel_x/pixel_y and never glitch.
//
// Ports
//   clk        in   system clock (single domain)
//   reset_n    in   synchronous, active-low reset
//   p_tick     out  one-clock pixel-enable pulse
//   pixel_x    out  horizontal position, 0..H_TOTAL-1
//   pixel_y    out  vertical position, 0..V_TOTAL-1
//   video_on   out  high inside the visible H_DISPLAY x V_DISPLAY area
//   hsync      out  horizontal sync, active-low
//   vsync      out  vertical sync, active-low
//   frame_end  out  one-clock pulse on the last pixel clock of a frame
//
// Legal parameter range: CLK_DIV 1..16, H_TOTAL and V_TOTAL each <= 1024.
// -----------------------------------------------------------------------------
module vga_sync_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_end
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [3:0] div_q, div_d;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;
  logic       tick;

  // Tick is decoded from the registered divider, so with CLK_DIV=1 it is a
  // constant 1 (div never leaves 0).
  assign tick = (div_q == DIV_LAST);

  always_comb begin
    div_d = tick ? 4'd0 : div_q + 4'd1;
    h_d   = h_q;
    v_d   = v_q;
    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = 10'd0;
        v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
    // Decode the next position so the registered syncs line up with pixel_x/y.
    hsync_d    = !((h_d >= HS_FIRST) && (h_d <= HS_LAST));
    vsync_d    = !((v_d >= VS_FIRST) && (v_d <= VS_LAST));
    video_on_d = (h_d < H_VIS) && (v_d < V_VIS);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_q      <= 4'd0;
      h_q        <= 10'd0;
      v_q        <= 10'd0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      video_on_q <= 1'b1;
    end else begin
      div_q      <= div_d;
      h_q        <= h_d;
      v_q        <= v_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      video_on_q <= video_on_d;
    end
  end

  assign p_tick    = tick;
  assign pixel_x   = h_q;
  assign pixel_y   = v_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign video_on  = video_on_q;
  assign frame_end = tick && (h_q == H_LAST) && (v_q == V_LAST);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Testbench for vga_sync_gen. Three instances share clock and reset:
//   d0 - default 640x480 timing, CLK_DIV=2 (reset values, one-line timing)
//   d1 - tiny 15x8 raster, CLK_DIV=2 (frame timing, coverage, mid-frame reset)
//   d2 - tiny 15x8 raster, CLK_DIV=1
// A reference model computes every output from the number of clocks since
// reset; expected vectors are queued on each edge and compared after it.
module tb_vga_sync_gen;

  localparam int SHD = 8, SHF = 2, SHS = 3, SHB = 2;
  localparam int SVD = 4, SVF = 1, SVS = 2, SVB = 1;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       pt0, pt1, pt2, von0, von1, von2, hs0, hs1, hs2, vs0, vs1, vs2, fe0, fe1, fe2;
  logic [9:0] x0, x1, x2, y0, y1, y2;

  vga_sync_gen d0 (
    .clk(clk), .reset_n(reset_n), .p_tick(pt0), .pixel_x(x0), .pixel_y(y0),
    .video_on(von0), .hsync(hs0), .vsync(vs0), .frame_end(fe0));

  vga_sync_gen #(.CLK_DIV(2), .H_DISPLAY(SHD), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_DISPLAY(SVD), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)) d1 (
    .clk(clk), .reset_n(reset_n), .p_tick(pt1), .pixel_x(x1), .pixel_y(y1),
    .video_on(von1), .hsync(hs1), .vsync(vs1), .frame_end(fe1));

  vga_sync_gen #(.CLK_DIV(1), .H_DISPLAY(SHD), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_DISPLAY(SVD), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)) d2 (
    .clk(clk), .reset_n(reset_n), .p_tick(pt2), .pixel_x(x2), .pixel_y(y2),
    .video_on(von2), .hsync(hs2), .vsync(vs2), .frame_end(fe2));

  // scoreboard state
  logic [74:0] exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;
  int n = 0;          // clocks since reset, as seen by the model
  int cyc = 0;        // sample index

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at sample %0d",
               tag, obs, obs, exp, exp, cyc);
    end
  endtask

  // Reference: position index = clocks / CLK_DIV, raster-scanned.
  function automatic logic [24:0] model(input int nn, input int cd,
      input int hd, input int hf, input int hs, input int hb,
      input int vd, input int vf, input int vs, input int vb);
    int ht, vt, p, x, y;
    logic pt, von, hsn, vsn, fe;
    ht  = hd + hf + hs + hb;
    vt  = vd + vf + vs + vb;
    pt  = ((nn % cd) == cd - 1);
    p   = nn / cd;
    x   = p % ht;
    y   = (p / ht) % vt;
    von = (x < hd) && (y < vd);
    hsn = !((x >= hd + hf) && (x < hd + hf + hs));
    vsn = !((y >= vd + vf) && (y < vd + vf + vs));
    fe  = pt && (x == ht - 1) && (y == vt - 1);
    return {pt, 10'(x), 10'(y), von, hsn, vsn, fe};
  endfunction

  // monitor state
  logic prev_hs0 = 1'b1, prev_von0 = 1'b1, prev_vs1 = 1'b1, prev_hs2 = 1'b1;
  logic [9:0] prev_x0 = '0;
  int hs0_w = 0, vs1_w = 0, hs2_w = 0;
  bit hs0_fall_done = 0, hs0_rise_done = 0, von0_fall_done = 0, von0_rise_done = 0;
  bit vs1_done = 0, hs2_done = 0;
  int last_fe1 = -1, last_fe2 = -1, fe1_cnt = 0, fe2_cnt = 0;
  int rst_cyc = -1;
  bit rst_pend1 = 0, rst_pend2 = 0;
  int max_x0 = 0, max_y0 = 0, max_x1 = 0, max_y1 = 0;
  int cov[SHD][SVD];
  int cov_out = 0;
  bit cov_active = 0, cov_done = 0;

  task automatic monitor();
    // d0 horizontal timing, first occurrence of each edge
    if (!hs0 && prev_hs0 && !hs0_fall_done) begin
      hs0_fall_done = 1;
      check("hs_fall_x", 32'(x0), 656);
      check("hs_fall_prev_x", 32'(prev_x0), 655);
    end
    if (hs0 && !prev_hs0 && !hs0_rise_done && hs0_fall_done) begin
      hs0_rise_done = 1;
      check("hs_rise_x", 32'(x0), 752);
      check("hs_low_width", 32'(hs0_w), 192);
    end
    hs0_w = hs0 ? 0 : hs0_w + 1;
    if (!von0 && prev_von0 && !von0_fall_done) begin
      von0_fall_done = 1;
      check("von_fall_x", 32'(x0), 640);
    end
    if (von0 && !prev_von0 && !von0_rise_done && von0_fall_done) begin
      von0_rise_done = 1;
      check("von_rise_x", 32'(x0), 0);
      check("von_rise_prev_x", 32'(prev_x0), 799);
    end
    // d1 vsync width: two lines of 15 pixels at 2 clocks each
    if (vs1 && !prev_vs1 && !vs1_done && vs1_w > 0) begin
      vs1_done = 1;
      check("vs_low_width", 32'(vs1_w), 60);
    end
    vs1_w = vs1 ? 0 : vs1_w + 1;
    // d2 hsync width: one clock per pixel
    if (hs2 && !prev_hs2 && !hs2_done && hs2_w > 0) begin
      hs2_done = 1;
      check("hs_low_width_div1", 32'(hs2_w), 3);
    end
    hs2_w = hs2 ? 0 : hs2_w + 1;
    // frame periods
    if (fe1 === 1'b1) begin
      fe1_cnt++;
      if (rst_pend1) begin
        check("fe_after_rst", 32'(cyc - rst_cyc), 239);
        rst_pend1 = 0;
      end
      if (last_fe1 >= 0) check("fe_period", 32'(cyc - last_fe1), 240);
      last_fe1 = cyc;
    end
    if (fe2 === 1'b1) begin
      fe2_cnt++;
      if (rst_pend2) begin
        check("fe_after_rst_div1", 32'(cyc - rst_cyc), 119);
        rst_pend2 = 0;
      end
      if (last_fe2 >= 0) check("fe_period_div1", 32'(cyc - last_fe2), 120);
      last_fe2 = cyc;
    end
    // visible-area coverage over one complete frame of d1
    if (cov_active && von1 === 1'b1) begin
      if (x1 < SHD && y1 < SVD) cov[x1][y1]++;
      else cov_out++;
    end
    if (fe1 === 1'b1 && !cov_done) begin
      if (cov_active) begin
        cov_active = 0;
        cov_done = 1;
        for (int i = 0; i < SHD; i++)
          for (int j = 0; j < SVD; j++)
            check($sformatf("vis_cnt_%0d_%0d", i, j), 32'(cov[i][j]), 2);
        check("vis_outside", 32'(cov_out), 0);
      end else begin
        cov_active = 1;
      end
    end
    if (int'(x0) > max_x0) max_x0 = int'(x0);
    if (int'(y0) > max_y0) max_y0 = int'(y0);
    if (int'(x1) > max_x1) max_x1 = int'(x1);
    if (int'(y1) > max_y1) max_y1 = int'(y1);
    prev_hs0 = hs0; prev_x0 = x0; prev_von0 = von0; prev_vs1 = vs1; prev_hs2 = hs2;
  endtask

  // driver: one clock; push expectation at the edge, compare at the negedge
  task automatic tick();
    logic [74:0] e;
    @(posedge clk);
    if (!reset_n) n = 0;
    else n = n + 1;
    exp_q.push_back({model(n, 2, 640, 16, 96, 48, 480, 10, 2, 33),
                     model(n, 2, SHD, SHF, SHS, SHB, SVD, SVF, SVS, SVB),
                     model(n, 1, SHD, SHF, SHS, SHB, SVD, SVF, SVS, SVB)});
    @(negedge clk);
    cyc++;
    e = exp_q.pop_front();
    check("sb_d0", 32'({pt0, x0, y0, von0, hs0, vs0, fe0}), 32'(e[74:50]));
    check("sb_d1", 32'({pt1, x1, y1, von1, hs1, vs1, fe1}), 32'(e[49:25]));
    check("sb_d2", 32'({pt2, x2, y2, von2, hs2, vs2, fe2}), 32'(e[24:0]));
    monitor();
  endtask

  logic [24:0] m1;
  bit found;

  initial begin
    for (int i = 0; i < SHD; i++)
      for (int j = 0; j < SVD; j++) cov[i][j] = 0;

    // reset for 5 clocks
    reset_n = 1'b0;
    repeat (5) tick();
    check("rst_x", 32'(x0), 0);
    check("rst_y", 32'(y0), 0);
    check("rst_hsync", 32'(hs0), 1);
    check("rst_vsync", 32'(vs0), 1);
    check("rst_video_on", 32'(von0), 1);
    check("rst_frame_end", 32'(fe0), 0);
    check("rst_p_tick", 32'(pt0), 0);
    check("rst_p_tick_div1", 32'(pt2), 1);

    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("ptick_seq", 32'(pt0), (k % 2 == 0) ? 1 : 0);
    end

    // free-run past the first full line of d0 and several d1 frames
    while (cyc < 2000) tick();

    // mid-frame reset on d1 at (11,5), where hsync and vsync are both low
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      tick();
      m1 = model(n, 2, SHD, SHF, SHS, SHB, SVD, SVF, SVS, SVB);
      if (m1[23:14] == 10'd11 && m1[13:4] == 10'd5) found = 1;
    end
    check("midrst_found", 32'(found), 1);
    if (found) begin
      check("mid_hsync_low", 32'(hs1), 0);
      check("mid_vsync_low", 32'(vs1), 0);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      rst_cyc = cyc;
      rst_pend1 = 1; rst_pend2 = 1;
      last_fe1 = -1; last_fe2 = -1;
      check("mid_x", 32'(x1), 0);
      check("mid_y", 32'(y1), 0);
      check("mid_hsync", 32'(hs1), 1);
      check("mid_vsync", 32'(vs1), 1);
      check("mid_video_on", 32'(von1), 1);
    end
    repeat (800) tick();

    check("max_x_small", 32'(max_x1), 14);
    check("max_y_small", 32'(max_y1), 7);
    check("max_x_le_799", 32'(max_x0 <= 799), 1);
    check("max_y_le_524", 32'(max_y0 <= 524), 1);
    check("hs_edges_seen", 32'(hs0_fall_done && hs0_rise_done), 1);
    check("von_edges_seen", 32'(von0_fall_done && von0_rise_done), 1);
    check("vs_seen", 32'(vs1_done), 1);
    check("hs_div1_seen", 32'(hs2_done), 1);
    check("cov_done", 32'(cov_done), 1);
    check("fe_after_rst_seen", 32'(rst_pend1 || rst_pend2), 0);
    check("fe_count", 32'(fe1_cnt >= 10), 1);
    check("fe_count_div1", 32'(fe2_cnt >= 20), 1);
    check("sb_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
